ccd_line_packer: RTL and testbench
==================================

Name: ccd_line_packer

Overview:
- Sits directly downstream of ccd_timing in the clk_80M domain.
- Consumes the per-pixel strobe and 16-bit ADC word and groups one CCD line into a framed byte stream.
- Frame format: header, then pixel bytes, MSB first.
- Output is a valid/ready byte stream for the USB transmit path (FT bus writer via clock-crossing FIFO). A small pixel FIFO absorbs backpressure.

Parameters:
- NUM_PIX, 3648, pixels per CCD line emitted in every frame (range 1..65535).
- FIFO_DEPTH, 64, pixel FIFO depth in words (power of two, >=4).
- SYNC_WORD, 16'hA55A, frame sync word.

Ports:
- clk_80M  in  1  system clock, 80 MHz, from pll_80.
- nrst  in  1  reset, synchronous, active-low.
- en  in  1  enables start of new frames.
- line_start  in  1  single-cycle pulse at CCD line start (SH).
- pix_clk  in  1  single-cycle pixel-valid strobe from ccd_timing.
- pix_data  in  16  ADC pixel word, valid when pix_clk=1.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts byte.
- line_cnt  out  16  number of frames started since reset.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- busy  out  1  high from frame start until the last byte is transferred.

Behaviour:
- Reset values (all registers cleared synchronously when nrst=0 at a clk_80M edge; reset dominates all other inputs):
  - out_data=0, out_valid=0, line_cnt=0, overflow=0, busy=0.
  - FIFO emptied, FSM in IDLE, capture counter 0.
- Handshake:
  - A byte transfers on a clock edge with out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - out_valid and out_data are registered.
- Frame format, in order:
  - SYNC hi, SYNC lo.
  - line number hi, lo: the value of line_cnt before increment.
  - NUM_PIX hi, lo.
  - NUM_PIX pixel words, each hi then lo.
  - Total bytes: 6 + 2*NUM_PIX (+2 with the optional feature).
- Frame start:
  - line_start=1 while en=1 and FSM in IDLE: latch line number, increment line_cnt (wraps at 65535 to 0), set busy, enter HDR.
  - First header byte presented with out_valid=1 on the next cycle (latency 1).
  - line_start while busy or en=0: ignored; no counter change.
- Capture:
  - Starts on the cycle after an accepted line_start.
  - Each pix_clk pushes pix_data into the FIFO until NUM_PIX strobes have been counted.
  - Further strobes are ignored until the next frame.
  - pix_clk with FIFO full: word dropped, strobe still counted, overflow set (sticky until reset).
  - Simultaneous push and pop when full: the push is still dropped; FIFO fullness is sampled before the pop.
- FSM states:
  - IDLE -> HDR on an accepted start.
  - HDR: 6 bytes, then PIX.
  - PIX, per word: pop the FIFO when a word is needed and the FIFO is non-empty; send hi, then lo.
  - If capture is complete (NUM_PIX strobes counted), the FIFO is empty, and emitted words < NUM_PIX: emit filler word 16'hFFFF, so frame length is always fixed.
  - Otherwise, with the FIFO empty: out_valid=0 and wait.
  - After the last pixel lo byte transfers: TRL (feature only) or IDLE.
  - busy falls on the cycle after the final transfer.
  - A line_start on that same final-transfer cycle is ignored.
- en deasserted mid-frame: the current frame completes normally; no new frame starts.
- Reset mid-frame: the frame is abandoned immediately; no partial bytes follow reset release.

Optional Feature:
- Macro LINE_CHECKSUM_EN.
- Defined:
  - State TRL appends 2 bytes (hi, lo): the 16-bit wrapping sum of all emitted pixel words, filler words included.
  - The sum clears at each frame start.
- Undefined: no TRL state; the frame ends after the last pixel byte.

Test Plan:
- NUM_PIX=4, out_ready=1, line_start, then pixels 0x1234, 0xABCD, 0x0001, 0xFFFE, line_cnt=0 -> bytes A5 5A 00 00 00 04 12 34 AB CD 00 01 FF FE; busy falls after the last byte; line_cnt=1.
- Same stimulus with out_ready toggled 1-0-1 every cycle -> identical byte sequence, out_data stable during stalls, overflow=0.
- FIFO_DEPTH=4, NUM_PIX=8, out_ready=0 until all 8 strobes are seen -> overflow=1; frame delivers the 4 stored words plus 4 filler words FFFF, 22 bytes total.
- line_start during an active frame, and line_start with en=0 -> no new header, line_cnt unchanged.
- Assert nrst for 1 cycle mid-PIX -> next cycle out_valid=0, busy=0, line_cnt=0; the next line_start produces a clean header with line number 0.
- LINE_CHECKSUM_EN, NUM_PIX=2, pixels 0xFFFF, 0x0003 -> trailer bytes 00 02.

Source files
------------

// File: rtl/ccd_line_packer.sv
`timescale 1ns/1ps
// ccd_line_packer: groups one CCD line of 16-bit ADC words into a framed, valid/ready byte stream.
// Define LINE_CHECKSUM_EN to append a 2-byte wrapping pixel-sum trailer to every frame.
//
// state | meaning
// IDLE  | no frame in progress, waiting for an accepted line_start
// HDR   | sending sync word, line number and pixel count (6 bytes)
// PIX   | sending pixel words (or filler) hi byte then lo byte
// TRL   | sending checksum hi/lo (LINE_CHECKSUM_EN builds only)
module ccd_line_packer #(
    parameter int unsigned NUM_PIX    = 3648,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
    input  logic        clk_80M,
    input  logic        nrst,
    input  logic        en,
    input  logic        line_start,
    input  logic        pix_clk,
    input  logic [15:0] pix_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] line_cnt,
    output logic        overflow,
    output logic        busy
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] NPIX      = 16'(NUM_PIX);
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] FILLER    = 16'hFFFF;

`ifdef LINE_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX, S_TRL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PIX} state_t;
`endif

    state_t        state_q, state_d;
    logic [2:0]    hdr_idx_q, hdr_idx_d;
    logic [15:0]   words_left_q, words_left_d;
    logic          lo_pend_q, lo_pend_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic          last_q, last_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [15:0]   line_cnt_q, line_cnt_d;
    logic [15:0]   line_num_q, line_num_d;
    logic          busy_q, busy_d;
    logic [15:0]   cap_left_q, cap_left_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fcnt_q, fcnt_d;
    logic [15:0]   fifo_mem_q [FIFO_DEPTH];
`ifdef LINE_CHECKSUM_EN
    logic [15:0]   sum_q, sum_d;
`endif

    logic        start;
    logic        pop;
    logic        push;
    logic        strobe;
    logic        fifo_full;
    logic        fifo_empty;
    logic        cap_done;
    logic        can_load;
    logic        xfer;
    logic [15:0] fifo_rdata;
    logic [15:0] word;

    assign xfer       = out_valid_q & out_ready;
    assign can_load   = ~out_valid_q | out_ready;
    assign fifo_full  = (fcnt_q == FIFO_FULL);
    assign fifo_empty = (fcnt_q == '0);
    assign fifo_rdata = fifo_mem_q[rd_ptr_q];
    assign cap_done   = (cap_left_q == 16'd0);
    assign strobe     = pix_clk & ~cap_done;
    // fullness is taken before any same-cycle pop, so a full FIFO always drops
    assign push       = strobe & ~fifo_full;

    always_comb begin
        cap_left_d = cap_left_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fcnt_d     = fcnt_q;
        overflow_d = overflow_q | (strobe & fifo_full);
        if (start) begin
            cap_left_d = NPIX;
        end else if (strobe) begin
            cap_left_d = cap_left_q - 16'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
            2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        words_left_d = words_left_q;
        lo_pend_d    = lo_pend_q;
        lo_byte_d    = lo_byte_q;
        last_d       = last_q;
        out_valid_d  = out_valid_q & ~out_ready;
        out_data_d   = out_data_q;
        line_cnt_d   = line_cnt_q;
        line_num_d   = line_num_q;
        busy_d       = busy_q;
        start        = 1'b0;
        pop          = 1'b0;
        word         = FILLER;
`ifdef LINE_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        if (last_q) begin
            // final byte is out; frame ends when it transfers
            if (xfer) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en && line_start) begin
                        start        = 1'b1;
                        line_num_d   = line_cnt_q;
                        line_cnt_d   = line_cnt_q + 16'd1;
                        busy_d       = 1'b1;
                        state_d      = S_HDR;
                        hdr_idx_d    = 3'd1;
                        words_left_d = NPIX;
                        lo_pend_d    = 1'b0;
                        out_valid_d  = 1'b1;
                        out_data_d   = SYNC_WORD[15:8];
`ifdef LINE_CHECKSUM_EN
                        sum_d        = 16'd0;
`endif
                    end
                end
                S_HDR: begin
                    if (can_load) begin
                        out_valid_d = 1'b1;
                        case (hdr_idx_q)
                            3'd1:    out_data_d = SYNC_WORD[7:0];
                            3'd2:    out_data_d = line_num_q[15:8];
                            3'd3:    out_data_d = line_num_q[7:0];
                            3'd4:    out_data_d = NPIX[15:8];
                            default: out_data_d = NPIX[7:0];
                        endcase
                        if (hdr_idx_q == 3'd5) begin
                            state_d = S_PIX;
                        end else begin
                            hdr_idx_d = hdr_idx_q + 3'd1;
                        end
                    end
                end
                S_PIX: begin
                    if (can_load) begin
                        if (lo_pend_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = lo_byte_q;
                            lo_pend_d   = 1'b0;
                            if (words_left_q == 16'd0) begin
`ifdef LINE_CHECKSUM_EN
                                state_d = S_TRL;
`else
                                last_d  = 1'b1;
`endif
                            end
                        end else if (!fifo_empty || cap_done) begin
                            // filler keeps the frame length fixed once capture can supply no more
                            if (!fifo_empty) begin
                                pop  = 1'b1;
                                word = fifo_rdata;
                            end
                            out_valid_d  = 1'b1;
                            out_data_d   = word[15:8];
                            lo_byte_d    = word[7:0];
                            lo_pend_d    = 1'b1;
                            words_left_d = words_left_q - 16'd1;
`ifdef LINE_CHECKSUM_EN
                            sum_d        = sum_q + word;
`endif
                        end
                    end
                end
`ifdef LINE_CHECKSUM_EN
                S_TRL: begin
                    if (can_load) begin
                        out_valid_d = 1'b1;
                        if (!lo_pend_q) begin
                            out_data_d = sum_q[15:8];
                            lo_byte_d  = sum_q[7:0];
                            lo_pend_d  = 1'b1;
                        end else begin
                            out_data_d = lo_byte_q;
                            lo_pend_d  = 1'b0;
                            last_d     = 1'b1;
                        end
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_80M) begin
        if (!nrst) begin
            state_q      <= S_IDLE;
            hdr_idx_q    <= 3'd0;
            words_left_q <= 16'd0;
            lo_pend_q    <= 1'b0;
            lo_byte_q    <= 8'd0;
            last_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            line_cnt_q   <= 16'd0;
            line_num_q   <= 16'd0;
            busy_q       <= 1'b0;
            cap_left_q   <= 16'd0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fcnt_q       <= '0;
`ifdef LINE_CHECKSUM_EN
            sum_q        <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            words_left_q <= words_left_d;
            lo_pend_q    <= lo_pend_d;
            lo_byte_q    <= lo_byte_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            line_cnt_q   <= line_cnt_d;
            line_num_q   <= line_num_d;
            busy_q       <= busy_d;
            cap_left_q   <= cap_left_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fcnt_q       <= fcnt_d;
`ifdef LINE_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk_80M) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= pix_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign line_cnt  = line_cnt_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ccd_line_packer.sv
`timescale 1ns/1ps
// Scoreboard bench for ccd_line_packer: expected frame bytes are queued as stimulus is issued
// and a negedge monitor compares every transferred byte, stall stability and busy timing.
module tb_ccd_line_packer;
    localparam int NUM_PIX    = 6;
    localparam int FIFO_DEPTH = 4;
    localparam logic [15:0] SYNC = 16'hA55A;
`ifdef LINE_CHECKSUM_EN
    localparam int TRL_BYTES = 2;
`else
    localparam int TRL_BYTES = 0;
`endif
    localparam int FRAME_BYTES = 6 + 2 * NUM_PIX + TRL_BYTES;

    logic        clk_80M = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_clk = 1'b0;
    logic [15:0] pix_data = 16'd0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [15:0] line_cnt;
    logic        overflow;
    logic        busy;

    ccd_line_packer #(.NUM_PIX(NUM_PIX), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_WORD(SYNC)) dut (
        .clk_80M(clk_80M), .nrst(nrst), .en(en), .line_start(line_start),
        .pix_clk(pix_clk), .pix_data(pix_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .line_cnt(line_cnt),
        .overflow(overflow), .busy(busy)
    );

    initial forever #5 clk_80M = ~clk_80M;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          rmode = 0;
    logic [15:0] mline = 16'd0;
    int          fr_counted = 0;
    int          fr_stored = 0;
    logic [15:0] fr_sum = 16'd0;
    bit          no_drain = 1'b0;
    int          rx_cnt = 0;
    bit          chk_idle = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    logic [15:0] pix_buf [NUM_PIX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_80M);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        fr_sum += w;
    endtask

    task automatic do_start(input bit accept);
        logic [15:0] np;
        np = 16'(NUM_PIX);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        if (accept) begin
            exp_q.push_back(SYNC[15:8]);
            exp_q.push_back(SYNC[7:0]);
            exp_q.push_back(mline[15:8]);
            exp_q.push_back(mline[7:0]);
            exp_q.push_back(np[15:8]);
            exp_q.push_back(np[7:0]);
            mline++;
            fr_counted = 0;
            fr_stored  = 0;
            fr_sum     = 16'd0;
        end
    endtask

    // a strobe counts until NUM_PIX are seen; once counted out, missing words become filler
    task automatic strobe(input logic [15:0] w, input bit ls);
        pix_clk = 1'b1;
        pix_data = w;
        line_start = ls;
        tick();
        pix_clk = 1'b0;
        line_start = 1'b0;
        if (fr_counted < NUM_PIX) begin
            fr_counted++;
            if (!no_drain || fr_stored < FIFO_DEPTH) begin
                push_word(w);
                fr_stored++;
            end
            if (fr_counted == NUM_PIX) begin
                for (int i = fr_stored; i < NUM_PIX; i++) push_word(16'hFFFF);
`ifdef LINE_CHECKSUM_EN
                exp_q.push_back(fr_sum[15:8]);
                exp_q.push_back(fr_sum[7:0]);
`endif
            end
        end
    endtask

    task automatic send_pixels(input int cnt, input int gmin, input int gmax,
                               input bit stray, input bit toggle_en);
        for (int i = 0; i < cnt; i++) begin
            repeat (int'($urandom_range(gmax, gmin)) - 1) tick();
            strobe(pix_buf[i], stray && (i == 2));
            if (toggle_en) en = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_line_cnt"}, 32'(line_cnt), 32'(mline));
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_PIX; i++) pix_buf[i] = 16'($urandom);
    endtask

    initial begin
        forever begin
            @(posedge clk_80M);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = out_ready ? 1'($urandom_range(1, 0)) : 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk_80M);
            if (!nrst) begin
                prev_stall = 1'b0;
                rx_cnt = 0;
                chk_idle = 1'b0;
            end else begin
                if (chk_idle) begin
                    check("busy_fall", 32'(busy), 32'd0);
                    chk_idle = 1'b0;
                end
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid) check("busy_during_frame", 32'(busy), 32'd1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_unexpected: got %h expected none", out_data);
                    end else begin
                        check($sformatf("byte%0d", rx_cnt), 32'(out_data), 32'(exp_q.pop_front()));
                    end
                    rx_cnt++;
                    if (rx_cnt == FRAME_BYTES) begin
                        rx_cnt = 0;
                        chk_idle = 1'b1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        nrst = 1'b1;
        en = 1'b1;
        rmode = 0;
        repeat (2) tick();

        pix_buf[0] = 16'h1234; pix_buf[1] = 16'hABCD; pix_buf[2] = 16'h0001;
        pix_buf[3] = 16'hFFFE; pix_buf[4] = 16'h5555; pix_buf[5] = 16'h0000;
        do_start(1'b1);
        send_pixels(NUM_PIX, 6, 6, 1'b0, 1'b0);
        wait_done("ready_high");

        rmode = 1;
        do_start(1'b1);
        send_pixels(NUM_PIX, 6, 6, 1'b0, 1'b0);
        wait_done("ready_toggle");
        check("toggle_overflow", 32'(overflow), 32'd0);

        rmode = 0;
        pix_buf[0] = 16'hFFFF; pix_buf[1] = 16'h0003;
        for (int i = 2; i < NUM_PIX; i++) pix_buf[i] = 16'h0000;
        do_start(1'b1);
        send_pixels(NUM_PIX, 6, 6, 1'b0, 1'b0);
        wait_done("sum_frame");

        fill_random();
        do_start(1'b1);
        send_pixels(NUM_PIX, 6, 8, 1'b1, 1'b0);
        wait_done("busy_start_ignored");
        en = 1'b0;
        do_start(1'b0);
        repeat (4) tick();
        check("en0_line_cnt", 32'(line_cnt), 32'(mline));
        check("en0_no_header", 32'(out_valid), 32'd0);
        en = 1'b1;

        rmode = 2;
        for (int f = 0; f < 12; f++) begin
            fill_random();
            en = 1'b1;
            do_start(1'b1);
            send_pixels(NUM_PIX, 6, 9, 1'($urandom_range(1, 0)), 1'b1);
            wait_done("random_frame");
        end
        check("random_overflow", 32'(overflow), 32'd0);
        en = 1'b1;

        rmode = 3;
        tick();
        fill_random();
        no_drain = 1'b1;
        do_start(1'b1);
        send_pixels(NUM_PIX, 1, 1, 1'b0, 1'b0);
        tick();
        check("overflow_set", 32'(overflow), 32'd1);
        no_drain = 1'b0;
        rmode = 0;
        wait_done("overflow_frame");
        check("overflow_sticky", 32'(overflow), 32'd1);

        fill_random();
        do_start(1'b1);
        send_pixels(3, 6, 6, 1'b0, 1'b0);
        n = 0;
        while (rx_cnt < 8 && n < 500) begin
            tick();
            n++;
        end
        check("reset_reached_pix", 32'(rx_cnt >= 8), 32'd1);
        nrst = 1'b0;
        exp_q.delete();
        mline = 16'd0;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_line_cnt", 32'(line_cnt), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        nrst = 1'b1;
        tick();
        fill_random();
        do_start(1'b1);
        send_pixels(NUM_PIX, 6, 7, 1'b0, 1'b0);
        wait_done("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
